// File: rtl/sta_tile_scheduler.sv
// sta_tile_scheduler
// Steps one conv/matmul layer through the SA_N x SA_N systolic-array complex.
// The output map is walked tile by tile in row-major order. For each tile the
// block pulses load_bias, issues k_steps operand-feed strobes, and then raises
// done. It holds done until the complex returns tile_out_valid.
// Optional feature: define STA_SCHED_TIMEOUT_EN to add a DRAIN watchdog. The
// watchdog sets a sticky timeout_err and abandons the layer if no result comes
// back within TIMEOUT_CYCLES. When the macro is absent, timeout_err is tied 0.

module sta_tile_scheduler #(
    parameter int SA_N           = 4,
    parameter int MAX_N          = 64,
    parameter int MAX_K          = 1024,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CTRL_N_BITS   = $clog2(MAX_N + 1),
    localparam int K_BITS        = $clog2(MAX_K + 1),
    localparam int FK_BITS       = $clog2(MAX_K),
    localparam int MASK_BITS     = SA_N * SA_N
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CTRL_N_BITS-1:0] out_h,
    input  logic [CTRL_N_BITS-1:0] out_w,
    input  logic [K_BITS-1:0]      k_steps,
    input  logic                   stall,
    input  logic                   tile_out_valid,
    output logic [CTRL_N_BITS-1:0] pos_row,
    output logic [CTRL_N_BITS-1:0] pos_col,
    output logic                   pe_mask [MASK_BITS],
    output logic                   load_bias,
    output logic                   feed_valid,
    output logic [FK_BITS-1:0]     feed_k,
    output logic                   done,
    output logic                   busy,
    output logic                   layer_done,
    output logic [15:0]            tile_count,
    output logic                   timeout_err
);

    // One extra bit so that pos+SA_N never wraps near MAX_N
    localparam int EXT_BITS = CTRL_N_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_FEED,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                 state;
    logic [CTRL_N_BITS-1:0] h_q;
    logic [CTRL_N_BITS-1:0] w_q;
    logic [K_BITS-1:0]      ks_q;
    logic [FK_BITS-1:0]     k_q;
    logic [MASK_BITS-1:0]   mask_q;
    logic                   bias_q;
    logic                   feed_q;
    logic                   tov_pending;

    logic [EXT_BITS-1:0]    row_end;
    logic [EXT_BITS-1:0]    col_end;
    logic                   last_tile;
    logic                   wrap_col;
    logic [CTRL_N_BITS-1:0] adv_row;
    logic [CTRL_N_BITS-1:0] adv_col;
    logic                   k_last;
    logic                   accept;
    logic [MASK_BITS-1:0]   start_mask;
    logic [MASK_BITS-1:0]   adv_mask;

    // Active PEs of the tile based at (r,c): rows below the map edge, cols left of it
    function automatic logic [MASK_BITS-1:0] tile_mask(
        input logic [CTRL_N_BITS-1:0] h,
        input logic [CTRL_N_BITS-1:0] w,
        input logic [CTRL_N_BITS-1:0] r,
        input logic [CTRL_N_BITS-1:0] c
    );
        logic [EXT_BITS-1:0]  rem_r;
        logic [EXT_BITS-1:0]  rem_c;
        logic [EXT_BITS-1:0]  rv;
        logic [EXT_BITS-1:0]  cv;
        logic [MASK_BITS-1:0] row_bits;
        logic [MASK_BITS-1:0] m;
        rem_r = EXT_BITS'(h) - EXT_BITS'(r);
        rem_c = EXT_BITS'(w) - EXT_BITS'(c);
        rv = (rem_r > EXT_BITS'(SA_N)) ? EXT_BITS'(SA_N) : rem_r;
        cv = (rem_c > EXT_BITS'(SA_N)) ? EXT_BITS'(SA_N) : rem_c;
        row_bits = '0;
        for (int j = 0; j < SA_N; j++) begin
            if (EXT_BITS'(j) < cv) begin
                row_bits = row_bits | (MASK_BITS'(1) << j);
            end
        end
        m = '0;
        for (int i = 0; i < SA_N; i++) begin
            if (EXT_BITS'(i) < rv) begin
                m = m | (row_bits << (i * SA_N));
            end
        end
        return m;
    endfunction

    assign row_end    = EXT_BITS'(pos_row) + EXT_BITS'(SA_N);
    assign col_end    = EXT_BITS'(pos_col) + EXT_BITS'(SA_N);
    assign last_tile  = (row_end >= EXT_BITS'(h_q)) && (col_end >= EXT_BITS'(w_q));
    assign wrap_col   = (col_end >= EXT_BITS'(w_q));
    assign adv_row    = wrap_col ? row_end[CTRL_N_BITS-1:0] : pos_row;
    assign adv_col    = wrap_col ? '0 : col_end[CTRL_N_BITS-1:0];
    assign k_last     = (K_BITS'(k_q) == (ks_q - K_BITS'(1)));
    assign accept     = tile_out_valid || tov_pending;
    assign start_mask = tile_mask(out_h, out_w, '0, '0);
    assign adv_mask   = tile_mask(h_q, w_q, adv_row, adv_col);

    // Strobes drop in any stalled cycle so that no bias load or operand beat is lost
    assign load_bias  = bias_q && !stall;
    assign feed_valid = feed_q && !stall;
    assign feed_k     = k_q;

    for (genvar b = 0; b < MASK_BITS; b++) begin : g_mask
        assign pe_mask[b] = mask_q[b];
    end

`ifdef STA_SCHED_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_BITS-1:0] wd_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Layer sequencing FSM with registered tile position, mask, counters and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            h_q         <= '0;
            w_q         <= '0;
            ks_q        <= '0;
            k_q         <= '0;
            pos_row     <= '0;
            pos_col     <= '0;
            mask_q      <= '0;
            bias_q      <= 1'b0;
            feed_q      <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            layer_done  <= 1'b0;
            tile_count  <= '0;
            tov_pending <= 1'b0;
`ifdef STA_SCHED_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else if (stall) begin
            if (state == S_DRAIN && tile_out_valid) begin
                tov_pending <= 1'b1;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        h_q        <= out_h;
                        w_q        <= out_w;
                        ks_q       <= k_steps;
                        pos_row    <= '0;
                        pos_col    <= '0;
                        tile_count <= '0;
                        busy       <= 1'b1;
                        if (out_h == '0 || out_w == '0 || k_steps == '0) begin
                            mask_q     <= '0;
                            layer_done <= 1'b1;
                            state      <= S_FINISH;
                        end else begin
                            mask_q <= start_mask;
                            bias_q <= 1'b1;
                            state  <= S_BIAS;
                        end
                    end
                end
                S_BIAS: begin
                    bias_q <= 1'b0;
                    feed_q <= 1'b1;
                    k_q    <= '0;
                    state  <= S_FEED;
                end
                S_FEED: begin
                    if (k_last) begin
                        feed_q <= 1'b0;
                        k_q    <= '0;
                        done   <= 1'b1;
                        state  <= S_DRAIN;
`ifdef STA_SCHED_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end else begin
                        k_q <= k_q + FK_BITS'(1);
                    end
                end
                S_DRAIN: begin
                    if (accept) begin
                        tov_pending <= 1'b0;
                        done        <= 1'b0;
                        tile_count  <= tile_count + 16'd1;
                        if (last_tile) begin
                            layer_done <= 1'b1;
                            state      <= S_FINISH;
                        end else begin
                            pos_row <= adv_row;
                            pos_col <= adv_col;
                            mask_q  <= adv_mask;
                            bias_q  <= 1'b1;
                            state   <= S_BIAS;
                        end
                    end
`ifdef STA_SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b0;
                        layer_done  <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + WD_BITS'(1);
                    end
`endif
                end
                S_FINISH: begin
                    layer_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sta_tile_scheduler.sv
// tb_sta_tile_scheduler
// Self-checking bench for sta_tile_scheduler. A tile-level reference model
// builds the row-major list of tile origins from the layer dimensions. The
// model derives each tile's PE mask from the map edges. It also expects
// feed_k to run 0..k-1 once per tile. A responder process returns
// tile_out_valid a few cycles after done.

module tb_sta_tile_scheduler;

    localparam int SA_N  = 4;
    localparam int MAX_N = 64;
    localparam int MAX_K = 1024;
    localparam int NB    = $clog2(MAX_N + 1);
    localparam int KB    = $clog2(MAX_K + 1);
    localparam int FKB   = $clog2(MAX_K);
    localparam int MB    = SA_N * SA_N;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NB-1:0] out_h;
    logic [NB-1:0] out_w;
    logic [KB-1:0] k_steps;
    logic          stall;
    logic          tile_out_valid;
    logic [NB-1:0] pos_row;
    logic [NB-1:0] pos_col;
    logic          pe_mask [MB];
    logic          load_bias;
    logic          feed_valid;
    logic [FKB-1:0] feed_k;
    logic          done;
    logic          busy;
    logic          layer_done;
    logic [15:0]   tile_count;
    logic          timeout_err;

    always #5 clk = ~clk;

    sta_tile_scheduler #(
        .SA_N(SA_N), .MAX_N(MAX_N), .MAX_K(MAX_K), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .out_h(out_h), .out_w(out_w),
        .k_steps(k_steps), .stall(stall), .tile_out_valid(tile_out_valid),
        .pos_row(pos_row), .pos_col(pos_col), .pe_mask(pe_mask),
        .load_bias(load_bias), .feed_valid(feed_valid), .feed_k(feed_k),
        .done(done), .busy(busy), .layer_done(layer_done),
        .tile_count(tile_count), .timeout_err(timeout_err)
    );

    typedef struct {
        int r;
        int c;
    } tile_t;

    int    checks = 0;
    int    errors = 0;
    tile_t exp_q[$];
    tile_t cur_tile;
    int    cur_h = 0;
    int    cur_w = 0;
    int    cur_k = 0;
    int    feeds_this = 0;
    int    feed_total = 0;
    int    ld_count = 0;
    logic  done_prev = 1'b0;
    logic  ld_prev = 1'b0;
    int    tov_enable = 1;
    int    tov_delay = 0;

    // Single comparison point: counts the check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Expected mask: PE(i,j) is live when its output pixel lies inside the map
    function automatic logic [31:0] modelMask(input int h, input int w, input int r, input int c);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < SA_N; i++) begin
            for (int j = 0; j < SA_N; j++) begin
                if ((r + i < h) && (c + j < w)) m[i*SA_N+j] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] packMask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < MB; i++) m[i] = pe_mask[i];
        return m;
    endfunction

    task automatic fillModel(input int h, input int w, input int k);
        tile_t t;
        cur_h = h;
        cur_w = w;
        cur_k = k;
        exp_q.delete();
        for (int r = 0; r < h; r += SA_N) begin
            for (int c = 0; c < w; c += SA_N) begin
                t.r = r;
                t.c = c;
                exp_q.push_back(t);
            end
        end
        feed_total = 0;
        ld_count = 0;
    endtask

    // Tile-level monitor: matches each tile against the model's next entry
    always @(negedge clk) begin
        if (reset) begin
            done_prev = 1'b0;
            ld_prev = 1'b0;
            feeds_this = 0;
        end else begin
            if (load_bias) begin
                checkOutput("tile_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur_tile = exp_q.pop_front();
                    checkOutput("pos_row", 32'(pos_row), cur_tile.r);
                    checkOutput("pos_col", 32'(pos_col), cur_tile.c);
                    checkOutput("pe_mask", packMask(), modelMask(cur_h, cur_w, cur_tile.r, cur_tile.c));
                end
                feeds_this = 0;
            end
            if (feed_valid) begin
                checkOutput("feed_k", 32'(feed_k), feeds_this);
                feeds_this++;
                feed_total++;
            end
            if (stall) checkOutput("stall_gate", 32'({load_bias, feed_valid}), 0);
            if (done && !done_prev) begin
                checkOutput("feeds_per_tile", feeds_this, cur_k);
                checkOutput("mask_hold", packMask(), modelMask(cur_h, cur_w, cur_tile.r, cur_tile.c));
            end
            if (layer_done && !ld_prev) ld_count++;
            done_prev = done;
            ld_prev = layer_done;
        end
    end

    // STA complex stand-in: returns one tile_out_valid pulse tov_delay cycles after done
    initial begin
        int  wait_cnt;
        bit  sent;
        wait_cnt = 0;
        sent = 1'b0;
        tile_out_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tile_out_valid = 1'b0;
            if (!done) begin
                sent = 1'b0;
                wait_cnt = 0;
            end else if (tov_enable != 0 && !sent) begin
                if (wait_cnt >= tov_delay) begin
                    tile_out_valid = 1'b1;
                    sent = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic pulseStart(input int h, input int w, input int k);
        @(posedge clk);
        #1;
        stall = 1'b0;
        out_h = NB'(h);
        out_w = NB'(w);
        k_steps = KB'(k);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one full layer; mode 0 = no stall, 1 = random stall, 2 = three-cycle stall at k=1
    task automatic applyStimulus(input int h, input int w, input int k, input int delay, input int mode);
        int ntiles;
        int stall_left;
        bit did;
        stall_left = 0;
        did = 1'b0;
        fillModel(h, w, k);
        ntiles = exp_q.size();
        tov_delay = delay;
        tov_enable = 1;
        pulseStart(h, w, k);
        for (int cyc = 0; cyc < 5000 && ld_count == 0; cyc++) begin
            if (mode == 1) begin
                stall = ($urandom_range(0, 3) == 0);
            end else if (mode == 2) begin
                if (stall_left > 0) begin
                    stall = 1'b1;
                    stall_left--;
                end else begin
                    stall = 1'b0;
                    if (!did && feed_k == FKB'(1)) begin
                        stall = 1'b1;
                        stall_left = 2;
                        did = 1'b1;
                    end
                end
                if (stall) begin
                    @(negedge clk);
                    checkOutput("stall_feed_valid", 32'(feed_valid), 0);
                    checkOutput("stall_feed_k", 32'(feed_k), 1);
                end
            end else begin
                stall = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("layer_done_pulses", ld_count, 1);
        checkOutput("tile_count", 32'(tile_count), ntiles);
        checkOutput("tiles_left", exp_q.size(), 0);
        checkOutput("feed_total", feed_total, ntiles * k);
        checkOutput("busy_after", 32'(busy), 0);
        checkOutput("timeout_err", 32'(timeout_err), 0);
        if (ld_count == 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    // Degenerate layer: no tile activity, FINISH right after start
    task automatic applyZeroLayer(input int h, input int w, input int k);
        fillModel(h, w, k);
        pulseStart(h, w, k);
        @(negedge clk);
        checkOutput("zero_layer_done_high", 32'(layer_done), 1);
        checkOutput("zero_busy_high", 32'(busy), 1);
        @(negedge clk);
        checkOutput("zero_layer_done_low", 32'(layer_done), 0);
        checkOutput("zero_busy_low", 32'(busy), 0);
        repeat (3) @(negedge clk);
        checkOutput("zero_pulses", ld_count, 1);
        checkOutput("zero_tile_count", 32'(tile_count), 0);
    endtask

    initial begin
        bit found;
        int n;
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        out_h = '0;
        out_w = '0;
        k_steps = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_layer_done", 32'(layer_done), 0);
        checkOutput("rst_tile_count", 32'(tile_count), 0);
        checkOutput("rst_pos", 32'({pos_row, pos_col}), 0);
        checkOutput("rst_mask", packMask(), 0);
        checkOutput("rst_strobes", 32'({load_bias, feed_valid, feed_k}), 0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 0);
        reset = 1'b0;

        $display("[TB] directed layers");
        applyStimulus(8, 8, 3, 5, 0);
        applyStimulus(6, 5, 2, 2, 0);
        applyStimulus(4, 4, 3, 1, 2);

        $display("[TB] zero-dimension layers");
        applyZeroLayer(8, 0, 3);
        applyZeroLayer(4, 4, 0);

        $display("[TB] start during stall");
        fillModel(0, 0, 0);
        @(posedge clk);
        #1;
        out_h = NB'(8);
        out_w = NB'(8);
        k_steps = KB'(2);
        start = 1'b1;
        stall = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stall = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("start_stall_busy", 32'(busy), 0);
        checkOutput("start_stall_pulses", ld_count, 0);

        $display("[TB] reset mid-layer");
        fillModel(8, 8, 2);
        tov_delay = 3;
        pulseStart(8, 8, 2);
        found = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            @(negedge clk);
            if (done && tile_count == 16'd1) found = 1'b1;
        end
        checkOutput("reset_reach_drain", 32'(found), 1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_done", 32'(done), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_tile_count", 32'(tile_count), 0);
        checkOutput("mid_rst_pos", 32'({pos_row, pos_col}), 0);
        checkOutput("mid_rst_mask", packMask(), 0);
        checkOutput("mid_rst_layer_done", 32'(layer_done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_rst_no_pulse", ld_count, 0);
        applyStimulus(4, 8, 2, 1, 0);

        $display("[TB] randomized layers");
        for (int t = 0; t < 6; t++) begin
            applyStimulus($urandom_range(1, 20), $urandom_range(1, 20),
                          $urandom_range(1, 6), $urandom_range(0, 4), 1);
        end

`ifdef STA_SCHED_TIMEOUT_EN
        $display("[TB] drain watchdog");
        tov_enable = 0;
        fillModel(4, 4, 1);
        pulseStart(4, 4, 1);
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        checkOutput("wd_reach_drain", 32'(found), 1);
        n = 1;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wd_cycles", n, 16);
        repeat (3) @(negedge clk);
        checkOutput("wd_layer_done", ld_count, 1);
        checkOutput("wd_tile_count", 32'(tile_count), 0);
        checkOutput("wd_sticky", 32'(timeout_err), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tov_enable = 1;
`else
        n = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
